// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with 16x oversampling, 2-flop input synchronizer and stop-bit error flag
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 CLK_100MHZ,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam int             NW     = $clog2(DATA_BITS);
    localparam logic [NW-1:0]  N_LAST = NW'(DATA_BITS - 1);
    localparam logic [3:0]     S_STOP = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            s_q, s_d;
    logic [NW-1:0]         n_q, n_d;
    logic [DATA_BITS-1:0]  b_q, b_d;
    logic [DATA_BITS-1:0]  dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  rx_meta_q, rx_s_q;

    // Synchronizer resets to the idle-line level so reset release never looks like a start bit
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DATA_BITS-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                // Outputs are registered, so the done pulse lines up with the new dout value
                if (tick) begin
                    if (s_q == S_STOP) begin
                        dout_d  = b_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with randomized frames and directed corner cases
module tb_uart_rx;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tick    = 1'b0;
    logic       rx      = 1'b1;
    logic       tick_en = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    // Each entry is {frame_err, data} as the line protocol says it should arrive
    logic [8:0] exp_q[$];

    uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut (
        .CLK_100MHZ  (clk),
        .reset       (rst_n),
        .tick        (tick),
        .rx          (rx),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c    = (c + 1) % 4;
            tick = tick_en && (c == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            do begin
                @(posedge clk);
                w++;
            end while (!tick && w < 3000);
            if (!tick) begin
                check("tick_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic drive_bit(input logic v, input int nt);
        @(negedge clk);
        rx = v;
        wait_ticks(nt);
    endtask

    // pause_bit stalls the tick stream mid-bit; abort_bit resets the DUT mid-bit
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int pause_bit, input int abort_bit);
        if (abort_bit < 0) exp_q.push_back({~stop, data});
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                drive_bit(data[i], 8);
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("abort_dout", dout, 8'h00);
                check("abort_ferr", frame_err, 1'b0);
                check("abort_done", rx_done_tick, 1'b0);
                repeat (3) @(negedge clk);
                rx    = 1'b1;
                rst_n = 1'b1;
                return;
            end else if (i == pause_bit) begin
                drive_bit(data[i], 8);
                tick_en = 1'b0;
                repeat (1000) @(posedge clk);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                drive_bit(data[i], 16);
            end
        end
        if (stop) begin
            drive_bit(1'b1, 16);
        end else begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 4);
            drive_bit(1'b1, 16);
        end
    endtask

    logic [7:0] prev_dout = 8'h00;
    logic       prev_fe   = 1'b0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            prev_dout = 8'h00;
            prev_fe   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (rx_done_tick) begin
                check("pulse_width", prev_done, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e[7:0]);
                    check("frame_err", frame_err, e[8]);
                end
            end else begin
                check("hold_dout", dout, prev_dout);
                check("hold_ferr", frame_err, prev_fe);
            end
            prev_dout = dout;
            prev_fe   = frame_err;
            prev_done = rx_done_tick;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        int         gap;

        repeat (5) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_done", rx_done_tick, 1'b0);
        rst_n = 1'b1;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1, -1, -1);

        drive_bit(1'b0, 3);
        drive_bit(1'b1, 40);
        check("glitch_dout", dout, 8'hA5);
        check("glitch_no_frame", exp_q.size(), 0);

        send_frame(8'h3C, 1'b0, -1, -1);
        send_frame(8'h00, 1'b1, -1, -1);

        send_frame(8'h55, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);

        send_frame(8'h96, 1'b1, -1, 4);
        wait_ticks(20);
        check("post_abort_dout", dout, 8'h00);
        send_frame(8'h81, 1'b1, -1, -1);

        send_frame(8'h6B, 1'b1, 3, -1);

        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 2);
            send_frame(d, sb, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
            drive_bit(1'b1, 16 * gap);
        end

        wait_ticks(40);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, number of data bits per frame (valid range 5..8).
REQ-002 SHALL provide parameter SB_TICK, default 16, oversampling ticks spent in the stop bit (16 = 1 stop bit).
REQ-003 SHALL have port CLK_100MHZ  input  1  system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port tick  input  1  one-cycle enable pulse from the baud rate generator, 16 pulses per bit period.
REQ-006 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port dout  output  DATA_BITS  last received data word.
REQ-008 SHALL have port rx_done_tick  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL have port frame_err  output  1  stop-bit value of the last frame was 0.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer reset to 1; all references to rx below mean the synchronized value rx_s.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, with 4-bit tick counter s, data-bit counter n of width clog2(DATA_BITS), and a DATA_BITS-wide shift register b.
REQ-012 IDLE: when rx_s==0 (sampled on any clock, tick not required), clear s and enter START.
REQ-013 START: on tick with s==7, check rx_s: if 0, clear s and n and enter DATA; if 1, treat as a glitch and return to IDLE with no output change; on other ticks, increment s.
REQ-014 DATA: on tick with s==15, clear s and shift rx_s into the MSB of b (LSB-first reception); then if n==DATA_BITS-1, enter STOP, else increment n; on other ticks, increment s.
REQ-015 STOP: on tick with s==SB_TICK-1, load dout<=b, set frame_err<=~rx_s, pulse rx_done_tick for exactly one clock, and enter IDLE; on other ticks, increment s.
REQ-016 SHALL leave all counters and state unchanged on clocks where tick==0, except for the IDLE start detection in REQ-012.
REQ-017 SHALL hold dout and frame_err stable between rx_done_tick pulses.
REQ-018 SHALL assert rx_done_tick even when frame_err is set; the consumer decides whether to discard the word.
REQ-019 SHALL accept back-to-back frames: a start edge seen in the cycle after rx_done_tick begins a new frame.
REQ-020 SHALL tolerate rx changes mid-bit; only the samples taken at REQ-013, REQ-014 and REQ-015 affect outputs.
REQ-021 SHALL make s wrap-free: it is always cleared before exceeding 15 (SB_TICK<=16).

Reset
REQ-022 reset==0 SHALL immediately force state to IDLE, s, n and b to 0, dout to 0, rx_done_tick to 0, frame_err to 0, and the synchronizer flops to 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick, and the block SHALL wait for a fresh falling edge after release.
REQ-024 Reset release SHALL be taken synchronously by the design; the first state update occurs on the first CLK_100MHZ edge after reset goes high.

Verification
REQ-025 Frame 0xA5 (start 0; bits 1,0,1,0,0,1,0,1 LSB first; stop 1), tick every 4 clocks, 16 ticks/bit -> one rx_done_tick, dout=0xA5, frame_err=0.
REQ-026 Low glitch of 3 ticks on idle rx -> returns to IDLE, no rx_done_tick, dout unchanged.
REQ-027 Frame 0x3C with stop bit 0 -> rx_done_tick, dout=0x3C, frame_err=1; a following good 0x00 frame -> frame_err=0.
REQ-028 Frames 0x55 and 0xFF back-to-back with no idle gap -> two pulses, dout=0x55 then 0xFF.
REQ-029 reset=0 during data bit 4 of a frame -> outputs 0, no pulse; next full 0x81 frame -> dout=0x81.
REQ-030 tick held at 0 for 1000 clocks mid-frame, then resumed -> frame completes correctly with no extra or missing bits.
